// File: rtl/nfp_shiftor_match_decoder.sv
// nfp_shiftor_match_decoder: turns shift-or state words into a serial stream of match byte offsets.
// Define NFP_DECODER_STATS_EN to add the stat_match_cnt / stat_drop_cnt counters.
module nfp_shiftor_match_decoder #(
    parameter int NFP_DWIDTH  = 128,
    parameter int FIFO_AWIDTH = 4,
    parameter int OFF_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NFP_DWIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [OFF_WIDTH-1:0]  out_offset,
    output logic                  out_hit,
    output logic                  out_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overflow
`ifdef NFP_DECODER_STATS_EN
    ,
    output logic [31:0]           stat_match_cnt,
    output logic [31:0]           stat_drop_cnt
`endif
);
    localparam int LANES = NFP_DWIDTH / 8;
    localparam int LW = $clog2(LANES);
    localparam int IW = OFF_WIDTH - LW;
    localparam int CW = FIFO_AWIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1 << FIFO_AWIDTH);

    typedef enum logic {IDLE, EMIT} state_t;
    state_t state;

    logic [IW-1:0] word_cnt, s1_idx;
    logic [LANES-1:0] h_in, s1_h;
    logic s1_valid, s1_last;
    logic [LANES-1:0] mem_h [1<<FIFO_AWIDTH];
    logic [IW-1:0] mem_idx [1<<FIFO_AWIDTH];
    logic mem_last [1<<FIFO_AWIDTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic [LANES-1:0] mask, rem, low, rest;
    logic [LW-1:0] lsb;
    logic push_req, full, fire, done, pop, push, drop;
    logic unused_data;

    assign unused_data = ^in_data;

    always_comb begin
        h_in = '0;
        for (int i = 0; i < LANES; i++) h_in[i] = ~in_data[8*i+7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_h     <= '0;
            s1_idx   <= '0;
            s1_last  <= 1'b0;
            word_cnt <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_h     <= h_in;
                s1_idx   <= word_cnt;
                s1_last  <= in_last;
                word_cnt <= in_last ? '0 : word_cnt + IW'(1);
            end
        end
    end

    // The FIFO head is the entry being emitted; mask records bits already sent.
    assign push_req   = s1_valid && (s1_h != '0 || s1_last);
    assign full       = count == DEPTH;
    assign rem        = mem_h[rd_ptr] & ~mask;
    assign low        = rem & (~rem + LANES'(1));
    assign rest       = rem & ~low;
    assign done       = rest == '0;
    assign out_valid  = state == EMIT;
    assign fire       = out_valid && out_ready;
    assign pop        = fire && done;
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign count_nxt  = count + CW'(push) - CW'(pop);
    assign overflow   = drop;
    assign out_hit    = out_valid && rem != '0;
    assign out_last   = out_valid && mem_last[rd_ptr] && done;
    assign out_offset = out_hit ? {mem_idx[rd_ptr], lsb} : '0;

    always_comb begin
        lsb = '0;
        for (int i = LANES - 1; i >= 0; i--) if (rem[i]) lsb = LW'(i);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_h[wr_ptr]    <= s1_h;
            mem_idx[wr_ptr]  <= s1_idx;
            mem_last[wr_ptr] <= s1_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            mask   <= '0;
            state  <= IDLE;
        end else begin
            count  <= count_nxt;
            wr_ptr <= push ? wr_ptr + FIFO_AWIDTH'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + FIFO_AWIDTH'(1) : rd_ptr;
            mask   <= pop ? '0 : fire ? (mask | low) : mask;
            state  <= count_nxt != '0 ? EMIT : IDLE;
        end
    end

`ifdef NFP_DECODER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_match_cnt <= '0;
            stat_drop_cnt  <= '0;
        end else begin
            if (fire && out_hit) stat_match_cnt <= stat_match_cnt + 32'd1;
            if (drop) stat_drop_cnt <= stat_drop_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_nfp_shiftor_match_decoder.sv
// tb_nfp_shiftor_match_decoder: directed scenario tests for the shift-or match decoder.
module tb_nfp_shiftor_match_decoder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] in_data = '1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [15:0] out_offset;
    logic out_hit, out_last, out_valid, overflow;
`ifdef NFP_DECODER_STATS_EN
    logic [31:0] stat_match_cnt, stat_drop_cnt;
`endif

    nfp_shiftor_match_decoder dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .out_offset(out_offset), .out_hit(out_hit), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .overflow(overflow)
`ifdef NFP_DECODER_STATS_EN
        , .stat_match_cnt(stat_match_cnt), .stat_drop_cnt(stat_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int ovf_cnt = 0;
    int chk = 0;
    int pass = 0;
    int q_off[$], q_hit[$], q_last[$], q_cyc[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (overflow) ovf_cnt++;
        if (out_valid && out_ready) begin
            q_off.push_back(int'(out_offset));
            q_hit.push_back(int'(out_hit));
            q_last.push_back(int'(out_last));
            q_cyc.push_back(cyc);
        end
    end

    function automatic logic [127:0] word_hit(input int b, input logic [7:0] v);
        logic [127:0] w;
        w = '1;
        w[8*b +: 8] = v;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] d, input logic l);
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        step();
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '1;
    endtask

    task automatic clear_q();
        q_off.delete();
        q_hit.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic test_reset();
        chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", out_valid); else pass++;
        chk++; if (out_hit !== 1'b0) $display("FAIL reset_hit: got %0b want 0", out_hit); else pass++;
        chk++; if (out_last !== 1'b0) $display("FAIL reset_last: got %0b want 0", out_last); else pass++;
        chk++; if (out_offset !== 16'd0) $display("FAIL reset_offset: got %0d want 0", out_offset); else pass++;
        chk++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b want 0", overflow); else pass++;
    endtask

    task automatic test_single_word();
        out_ready = 1'b1;
        drive(word_hit(3, 8'h7F), 1'b1);
        chk++; if (out_valid !== 1'b0) $display("FAIL single_t1_valid: got %0b want 0", out_valid); else pass++;
        step();
        chk++; if (out_valid !== 1'b1) $display("FAIL single_t2_valid: got %0b want 1", out_valid); else pass++;
        chk++; if (out_offset !== 16'd3) $display("FAIL single_offset: got %0d want 3", out_offset); else pass++;
        chk++; if (out_hit !== 1'b1) $display("FAIL single_hit: got %0b want 1", out_hit); else pass++;
        chk++; if (out_last !== 1'b1) $display("FAIL single_last: got %0b want 1", out_last); else pass++;
        step();
        chk++; if (out_valid !== 1'b0) $display("FAIL single_drain: got %0b want 0", out_valid); else pass++;
    endtask

    task automatic test_three_word();
        logic [127:0] w;
        clear_q();
        w = '1;
        w[7:0] = 8'h00;
        w[127:120] = 8'h00;
        drive('1, 1'b0);
        drive('1, 1'b0);
        drive(w, 1'b1);
        repeat (4) step();
        chk++; if (q_off.size() !== 2) $display("FAIL three_count: got %0d want 2", q_off.size()); else pass++;
        if (q_off.size() == 2) begin
            chk++; if (q_off[0] !== 32 || q_hit[0] !== 1 || q_last[0] !== 0) $display("FAIL three_beat0: got off %0d hit %0d last %0d want 32 1 0", q_off[0], q_hit[0], q_last[0]); else pass++;
            chk++; if (q_off[1] !== 47 || q_hit[1] !== 1 || q_last[1] !== 1) $display("FAIL three_beat1: got off %0d hit %0d last %0d want 47 1 1", q_off[1], q_hit[1], q_last[1]); else pass++;
            chk++; if (q_cyc[1] - q_cyc[0] !== 1) $display("FAIL three_b2b: got gap %0d want 1", q_cyc[1] - q_cyc[0]); else pass++;
        end
    endtask

    task automatic test_no_hit();
        clear_q();
        drive('1, 1'b0);
        drive('1, 1'b0);
        drive('1, 1'b1);
        repeat (4) step();
        chk++; if (q_off.size() !== 1) $display("FAIL nohit_count: got %0d want 1", q_off.size()); else pass++;
        if (q_off.size() == 1) begin
            chk++; if (q_off[0] !== 0 || q_hit[0] !== 0 || q_last[0] !== 1) $display("FAIL nohit_beat: got off %0d hit %0d last %0d want 0 0 1", q_off[0], q_hit[0], q_last[0]); else pass++;
        end
    endtask

    task automatic test_backpressure_overflow();
        int ovf0;
        clear_q();
        out_ready = 1'b0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 20; i++) begin
            drive(word_hit(0, 8'h7F), 1'b0);
            chk++; if (overflow !== (i >= 16)) $display("FAIL ovf_word%0d: got %0b want %0b", i, overflow, i >= 16); else pass++;
        end
        step();
        chk++; if (ovf_cnt - ovf0 !== 4) $display("FAIL ovf_pulses: got %0d want 4", ovf_cnt - ovf0); else pass++;
`ifdef NFP_DECODER_STATS_EN
        chk++; if (stat_drop_cnt !== 32'd4) $display("FAIL stat_drop: got %0d want 4", stat_drop_cnt); else pass++;
`endif
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (3) step();
        chk++; if (out_valid !== 1'b1 || out_offset !== 16'd16 || out_hit !== 1'b1 || out_last !== 1'b0) $display("FAIL stall_hold: got v %0b off %0d hit %0b last %0b want 1 16 1 0", out_valid, out_offset, out_hit, out_last); else pass++;
        out_ready = 1'b1;
        repeat (20) step();
        chk++; if (q_off.size() !== 16) $display("FAIL bp_count: got %0d want 16", q_off.size()); else pass++;
        for (int i = 0; i < q_off.size() && i < 16; i++) begin
            chk++; if (q_off[i] !== 16 * i || q_last[i] !== 0) $display("FAIL bp_beat%0d: got off %0d last %0d want %0d 0", i, q_off[i], q_last[i], 16 * i); else pass++;
        end
        for (int i = 2; i < q_cyc.size() && i < 16; i++) begin
            chk++; if (q_cyc[i] - q_cyc[i-1] !== 1) $display("FAIL bp_rate%0d: got gap %0d want 1", i, q_cyc[i] - q_cyc[i-1]); else pass++;
        end
        clear_q();
        drive('1, 1'b1);
        repeat (4) step();
        chk++; if (q_off.size() !== 1 || q_hit[0] !== 0 || q_last[0] !== 1 || q_off[0] !== 0) $display("FAIL bp_close: got %0d beats want one 0/0/1 marker", q_off.size()); else pass++;
    endtask

    task automatic test_back_to_back_full();
        int ovf0;
        clear_q();
        out_ready = 1'b0;
        ovf0 = ovf_cnt;
        for (int i = 0; i < 16; i++) drive(word_hit(2, 8'h7F), 1'b0);
        drive(word_hit(2, 8'h7F), 1'b1);
        chk++; if (overflow !== 1'b1) $display("FAIL full_reached: got overflow %0b want 1 while stalled", overflow); else pass++;
        out_ready = 1'b1;
        #1;
        chk++; if (overflow !== 1'b0) $display("FAIL full_pushpop: got overflow %0b want 0", overflow); else pass++;
        repeat (25) step();
        chk++; if (ovf_cnt - ovf0 !== 0) $display("FAIL full_ovf_cnt: got %0d want 0", ovf_cnt - ovf0); else pass++;
        chk++; if (q_off.size() !== 17) $display("FAIL full_count: got %0d want 17", q_off.size()); else pass++;
        for (int i = 0; i < q_off.size() && i < 17; i++) begin
            chk++; if (q_off[i] !== 16 * i + 2 || q_last[i] !== int'(i == 16)) $display("FAIL full_beat%0d: got off %0d last %0d want %0d %0d", i, q_off[i], q_last[i], 16 * i + 2, i == 16); else pass++;
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_q();
        out_ready = 1'b1;
        drive(word_hit(0, 8'h7F), 1'b0);
        drive(word_hit(1, 8'h7F), 1'b0);
        chk++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %0b want 1", out_valid); else pass++;
        rst_n = 1'b0;
        #1;
        chk++; if (out_valid !== 1'b0 || out_offset !== 16'd0 || out_hit !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0) $display("FAIL mid_reset_outs: got v %0b off %0d hit %0b last %0b ovf %0b want all 0", out_valid, out_offset, out_hit, out_last, overflow); else pass++;
        repeat (2) step();
        rst_n = 1'b1;
        clear_q();
        step();
        drive(word_hit(5, 8'h7F), 1'b1);
        repeat (4) step();
        chk++; if (q_off.size() !== 1) $display("FAIL mid_count: got %0d want 1", q_off.size()); else pass++;
        if (q_off.size() == 1) begin
            chk++; if (q_off[0] !== 5 || q_hit[0] !== 1 || q_last[0] !== 1) $display("FAIL mid_beat: got off %0d hit %0d last %0d want 5 1 1", q_off[0], q_hit[0], q_last[0]); else pass++;
        end
    endtask

    initial begin
        repeat (3) step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_single_word();
        test_three_word();
        test_no_hit();
        test_backpressure_overflow();
        test_back_to_back_full();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
